rat_reduce: RTL and testbench

//   Normalises an unsigned rational num/den to lowest terms by dividing both by gcd(num,den).

---
 rtl/rat_reduce.sv | 159 +++++++++++++++
 tb/tb_rat_reduce.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rat_reduce.sv
// rat_reduce: reduces an unsigned rational num/den to lowest terms.
// Stein GCD, then two parallel restoring dividers by the GCD.
module rat_reduce #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_num,
  input  logic [WIDTH-1:0] in_den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_num,
  output logic [WIDTH-1:0] out_den,
  output logic             out_err
);

  localparam int KW = $clog2(WIDTH) + 1;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    GCD,
    DIV,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a, b, g;
  logic [KW-1:0]    k;
  logic [CW-1:0]    cnt;
  // qn/qd start as the dividends and shift the quotient bits in
  logic [WIDTH-1:0] qn, qd, rn, rd;

  logic accept, zero_den, zero_num;
  logic both_odd, last;

  logic [WIDTH:0]   tn, td;
  logic             gn, gd;
  logic [WIDTH-1:0] qn_nx, qd_nx, rn_nx, rd_nx;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign zero_den  = (in_den == '0);
  assign zero_num  = (in_num == '0);
  assign both_odd  = a[0] && b[0];
  assign last      = (cnt == CW'(WIDTH - 1));

  // One restoring-division step for both dividers
  always_comb begin
    tn    = {rn, qn[WIDTH-1]};
    td    = {rd, qd[WIDTH-1]};
    gn    = (tn >= {1'b0, g});
    gd    = (td >= {1'b0, g});
    rn_nx = gn ? WIDTH'(tn - {1'b0, g}) : tn[WIDTH-1:0];
    rd_nx = gd ? WIDTH'(td - {1'b0, g}) : td[WIDTH-1:0];
    qn_nx = {qn[WIDTH-2:0], gn};
    qd_nx = {qd[WIDTH-2:0], gd};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept)
          state_nx = (zero_den || zero_num) ? DONE : GCD;
      end
      GCD: begin
        if (both_odd && (a == b)) state_nx = DIV;
      end
      DIV: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
    endcase
  end

  // Datapath: capture, GCD steps, division, result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a       <= '0;
      b       <= '0;
      g       <= '0;
      k       <= '0;
      cnt     <= '0;
      qn      <= '0;
      qd      <= '0;
      rn      <= '0;
      rd      <= '0;
      out_num <= '0;
      out_den <= '0;
      out_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a   <= in_num;
            b   <= in_den;
            k   <= '0;
            cnt <= '0;
            qn  <= in_num;
            qd  <= in_den;
            rn  <= '0;
            rd  <= '0;
            if (zero_den) begin
              out_num <= '0;
              out_den <= '0;
              out_err <= 1'b1;
            end else if (zero_num) begin
              out_num <= '0;
              out_den <= WIDTH'(1);
              out_err <= 1'b0;
            end
          end
        end
        GCD: begin
          unique case (1'b1)
            !a[0] && !b[0]: begin
              a <= a >> 1;
              b <= b >> 1;
              k <= k + 1'b1;
            end
            !a[0] && b[0]:           a <= a >> 1;
            a[0] && !b[0]:           b <= b >> 1;
            both_odd && (a == b):    g <= a << k;
            both_odd && (a > b):     a <= a - b;
            both_odd && (a < b):     b <= b - a;
          endcase
        end
        DIV: begin
          qn  <= qn_nx;
          qd  <= qd_nx;
          rn  <= rn_nx;
          rd  <= rd_nx;
          cnt <= cnt + 1'b1;
          if (last) begin
            out_num <= qn_nx;
            out_den <= qd_nx;
            out_err <= 1'b0;
          end
        end
        DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rat_reduce.sv
// tb_rat_reduce: directed vectors, backpressure, reset
// and random reduction checks for rat_reduce at WIDTH=8.
module tb_rat_reduce;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_num = '0;
  logic [W-1:0] in_den = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_num;
  logic [W-1:0] out_den;
  logic         out_err;

  int total = 0;
  int bad   = 0;

  rat_reduce #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_num   (in_num),
    .in_den   (in_den),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_num  (out_num),
    .out_den  (out_den),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic [W-1:0] en;
    logic [W-1:0] ed;
    logic         ee;
    int           lat;
  } vec_t;

  vec_t tv[11];

  task automatic chk(input string nm,
                     input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic int gcd_ref(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Present one pair, accept it, count edges until out_valid
  task automatic job(input logic [W-1:0] n,
                     input logic [W-1:0] d,
                     output int lat);
    int w;
    @(negedge clk);
    in_num   = n;
    in_den   = d;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic xfer();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("xfer_in_ready", int'(in_ready), 1);
    chk("xfer_out_valid", int'(out_valid), 0);
  endtask

  initial begin
    int lat;
    int g, w, c;
    logic [W-1:0] n, d;

    tv[0]  = '{8'd12,  8'd18,  8'd2,  8'd3,   1'b0, 13};
    tv[1]  = '{8'd0,   8'd7,   8'd0,  8'd1,   1'b0, 0};
    tv[2]  = '{8'd9,   8'd0,   8'd0,  8'd0,   1'b1, 0};
    tv[3]  = '{8'd7,   8'd5,   8'd7,  8'd5,   1'b0, 14};
    tv[4]  = '{8'd255, 8'd255, 8'd1,  8'd1,   1'b0, 9};
    tv[5]  = '{8'd128, 8'd64,  8'd2,  8'd1,   1'b0, 16};
    tv[6]  = '{8'd100, 8'd75,  8'd4,  8'd3,   1'b0, -1};
    tv[7]  = '{8'd200, 8'd8,   8'd25, 8'd1,   1'b0, -1};
    tv[8]  = '{8'd1,   8'd255, 8'd1,  8'd255, 1'b0, -1};
    tv[9]  = '{8'd0,   8'd0,   8'd0,  8'd0,   1'b1, 0};
    tv[10] = '{8'd4,   8'd6,   8'd2,  8'd3,   1'b0, 13};

    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_num", int'(out_num), 0);
    chk("rst_out_den", int'(out_den), 0);
    chk("rst_out_err", int'(out_err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      job(tv[i].n, tv[i].d, lat);
      chk($sformatf("v%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("v%0d_num", i), int'(out_num), int'(tv[i].en));
      chk($sformatf("v%0d_den", i), int'(out_den), int'(tv[i].ed));
      chk($sformatf("v%0d_err", i), int'(out_err), int'(tv[i].ee));
      if (tv[i].lat >= 0)
        chk($sformatf("v%0d_lat", i), lat, tv[i].lat);
      xfer();
    end

    // Backpressure: hold result, ignore new input while busy
    job(8'd12, 8'd18, lat);
    chk("bp_lat", lat, 13);
    in_valid = 1'b1;
    in_num   = 8'd5;
    in_den   = 8'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_num", int'(out_num), 2);
      chk("bp_den", int'(out_den), 3);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    xfer();
    chk("bp_num_kept", int'(out_num), 2);

    // Reset during DIV of 12/18
    @(negedge clk);
    in_num   = 8'd12;
    in_den   = 8'd18;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mr_out_valid", int'(out_valid), 0);
    chk("mr_in_ready", int'(in_ready), 1);
    chk("mr_out_num", int'(out_num), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mr_idle_valid", int'(out_valid), 0);
    job(8'd4, 8'd6, lat);
    chk("mr_lat", lat, 13);
    chk("mr_num", int'(out_num), 2);
    chk("mr_den", int'(out_den), 3);
    chk("mr_err", int'(out_err), 0);
    xfer();

    // Random pairs, in_valid held high, out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      n = W'($urandom_range(1, 255));
      d = W'($urandom_range(1, 255));
      @(negedge clk);
      in_num   = n;
      in_den   = d;
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      chk("rnd_ready", int'(in_ready), 1);
      @(posedge clk);
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!out_valid && c < 100);
      chk("rnd_valid", int'(out_valid), 1);
      g = gcd_ref(int'(n), int'(d));
      chk("rnd_num", int'(out_num) * g, int'(n));
      chk("rnd_den", int'(out_den) * g, int'(d));
      chk("rnd_coprime",
          gcd_ref(int'(out_num), int'(out_den)), 1);
      chk("rnd_err", int'(out_err), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
